// File: rtl/jtcps1_pkg.sv
// Shared types and defaults for the CPS1 SDRAM programming path.
`timescale 1ns/1ps
package jtcps1_pkg;

  localparam int          FIFO_AW_DEF = 2;
  localparam logic [21:0] CLR_END_DEF = 22'h3FFFFF;
  localparam logic [1:0]  CLR_BA_DEF  = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } sched_st_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [1:0]  ba;
  } prog_wr_t;

endpackage

// File: rtl/jtcps1_prog_fifo.sv
// Loader write queue; a pop frees a full slot for a same-cycle push.
`timescale 1ns/1ps
module jtcps1_prog_fifo
  import jtcps1_pkg::*;
#(
  parameter int AW = FIFO_AW_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  prog_wr_t din,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output prog_wr_t head
);

  localparam int DEPTH = 1 << AW;

  prog_wr_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = cnt == '0;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtcps1_prog_sched.sv
// Schedules loader writes and the post-download clear pass onto
// the SDRAM programming port.
`timescale 1ns/1ps
module jtcps1_prog_sched
  import jtcps1_pkg::*;
#(
  parameter int          FIFO_AW = FIFO_AW_DEF,
  parameter logic [21:0] CLR_END = CLR_END_DEF,
  parameter logic [1:0]  CLR_BA  = CLR_BA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        ld_we,
  input  logic [21:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic [1:0]  ld_mask,
  input  logic [1:0]  ld_ba,
  input  logic        clr_en,
  output logic        prog_we,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  input  logic        prog_rdy,
  output logic        busy,
  output logic        ovf
);

  sched_st_t   st;
  logic [21:0] cnt;
  logic        src_fifo;
  prog_wr_t    din;
  prog_wr_t    head;
  logic        full;
  logic        empty;
  logic        ack;
  logic        clr_ack;
  logic        pop;

  assign din     = '{addr: ld_addr, data: ld_data,
                     mask: ld_mask, ba: ld_ba};
  assign ack     = prog_we & prog_rdy;
  assign clr_ack = ack & ~src_fifo;
  assign pop     = ack & src_fifo;
  assign busy    = ~empty | prog_we | (st == ST_CLEAR);

  jtcps1_prog_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ld_we),
    .din   (din),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      src_fifo  <= 1'b0;
      ovf       <= 1'b0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_ba   <= '0;
    end else begin
      if (ld_we & full & ~pop) ovf <= 1'b1;

      unique case (st)
        ST_IDLE:
          if (downloading) st <= ST_LOAD;
        ST_LOAD:
          if (~downloading & empty) begin
            st  <= clr_en ? ST_CLEAR : ST_IDLE;
            cnt <= '0;
          end
        ST_CLEAR:
          if (downloading)
            st <= ST_LOAD;
          else if (clr_ack && cnt == CLR_END)
            st <= ST_IDLE;
        default:
          st <= ST_IDLE;
      endcase

      if (st == ST_CLEAR && clr_ack && cnt != CLR_END)
        cnt <= cnt + 22'd1;

      // queued loader words always win over the next clear word
      if (prog_we) begin
        if (ack)
          prog_we <= 1'b0;
        else if (st == ST_CLEAR && downloading && !src_fifo)
          prog_we <= 1'b0;
      end else if (!empty) begin
        prog_we   <= 1'b1;
        src_fifo  <= 1'b1;
        prog_addr <= head.addr;
        prog_data <= head.data;
        prog_mask <= head.mask;
        prog_ba   <= head.ba;
      end else if (st == ST_CLEAR && !downloading) begin
        prog_we   <= 1'b1;
        src_fifo  <= 1'b0;
        prog_addr <= cnt;
        prog_data <= '0;
        prog_mask <= 2'b00;
        prog_ba   <= CLR_BA;
      end
    end
  end

endmodule

// File: tb/tb_jtcps1_prog_sched.sv
// Directed scoreboard bench for jtcps1_prog_sched.
`timescale 1ns/1ps
module tb_jtcps1_prog_sched;
  import jtcps1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        ld_we = 1'b0;
  logic [21:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [1:0]  ld_mask = '0;
  logic [1:0]  ld_ba = '0;
  logic        clr_en = 1'b0;
  logic        prog_we;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_rdy = 1'b0;
  logic        busy;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit hold = 1'b0;
  int lat = 3;
  int wcnt = 0;
  bit fall_pend = 1'b0;
  prog_wr_t exp_q[$];

  jtcps1_prog_sched #(.CLR_END(22'h000003)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_mask     (ld_mask),
    .ld_ba       (ld_ba),
    .clr_en      (clr_en),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_rdy    (prog_rdy),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [21:0] a,
                           input logic [15:0] d,
                           input logic [1:0] m,
                           input logic [1:0] b);
    prog_wr_t e;
    e = '{addr: a, data: d, mask: m, ba: b};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ld_pulse(input logic [21:0] a,
                          input logic [15:0] d,
                          input logic [1:0] m,
                          input logic [1:0] b);
    ld_we = 1'b1;
    ld_addr = a;
    ld_data = d;
    ld_mask = m;
    ld_ba = b;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk(nm, 64'(n < 300), 64'd1);
  endtask

  // responder and scoreboard monitor share one process
  always @(negedge clk) begin
    if (fall_pend) begin
      chk("we_fall", 64'(prog_we), 64'd0);
      fall_pend = 1'b0;
    end
    if (!rst_n || !prog_we || hold) begin
      prog_rdy = 1'b0;
      wcnt = 0;
    end else if (prog_rdy) begin
      prog_rdy = 1'b0;
    end else begin
      wcnt++;
      if (wcnt >= lat) begin
        prog_rdy = 1'b1;
        fall_pend = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr: unexpected write addr %0h", prog_addr);
        end else begin
          prog_wr_t e;
          e = exp_q.pop_front();
          chk("wr", {prog_addr, prog_data, prog_mask, prog_ba}, 64'(e));
        end
      end
    end
  end

  initial begin
    int n;
    tick();
    tick();
    chk("rst_we", 64'(prog_we), 64'd0);
    chk("rst_mask", 64'(prog_mask), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // single loader write
    downloading = 1'b1;
    tick();
    expect_wr(22'h000010, 16'hA55A, 2'b10, 2'd0);
    ld_pulse(22'h000010, 16'hA55A, 2'b10, 2'd0);
    chk("s1_we_lat0", 64'(prog_we), 64'd0);
    chk("s1_busy", 64'(busy), 64'd1);
    tick();
    chk("s1_we_lat1", 64'(prog_we), 64'd1);
    chk("s1_addr", 64'(prog_addr), 64'h10);
    wait_idle("s1_done");

    // overflow with acknowledge withheld
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        expect_wr(22'h20 + 22'(i), 16'h1000 + 16'(i), 2'b01, 2'd1);
      ld_pulse(22'h20 + 22'(i), 16'h1000 + 16'(i), 2'b01, 2'd1);
    end
    tick();
    chk("s2_ovf", 64'(ovf), 64'd1);
    chk("s2_full", 64'(dut.u_fifo.full), 64'd1);
    chk("s2_hold_addr", 64'(prog_addr), 64'h20);
    chk("s2_hold_we", 64'(prog_we), 64'd1);
    hold = 1'b0;
    wait_idle("s2_done");

    // full clear pass
    for (int i = 0; i < 4; i++)
      expect_wr(22'(i), 16'h0, 2'b00, 2'd0);
    clr_en = 1'b1;
    downloading = 1'b0;
    wait_idle("s3_done");
    chk("s3_state", 64'(dut.st), 64'(ST_IDLE));
    chk("s3_busy", 64'(busy), 64'd0);

    // abort the clear at counter 2
    downloading = 1'b1;
    tick();
    expect_wr(22'h0, 16'h0, 2'b00, 2'd0);
    expect_wr(22'h1, 16'h0, 2'b00, 2'd0);
    downloading = 1'b0;
    n = 0;
    while (dut.cnt != 22'd2 && n < 100) begin
      tick();
      n++;
    end
    chk("s4_cnt2", 64'(n < 100), 64'd1);
    hold = 1'b1;
    tick();
    chk("s4_pend_we", 64'(prog_we), 64'd1);
    chk("s4_pend_addr", 64'(prog_addr), 64'h2);
    downloading = 1'b1;
    tick();
    chk("s4_state", 64'(dut.st), 64'(ST_LOAD));
    chk("s4_dropped", 64'(prog_we), 64'd0);
    hold = 1'b0;
    repeat (12) tick();
    chk("s4_q_empty", 64'(exp_q.size()), 64'd0);

    // loader write during clear goes first
    hold = 1'b1;
    expect_wr(22'h0, 16'h0, 2'b00, 2'd0);
    downloading = 1'b0;
    tick();
    tick();
    chk("s5_clr0_we", 64'(prog_we), 64'd1);
    expect_wr(22'h2AAAAA, 16'hBEEF, 2'b11, 2'd3);
    for (int i = 1; i < 4; i++)
      expect_wr(22'(i), 16'h0, 2'b00, 2'd0);
    ld_pulse(22'h2AAAAA, 16'hBEEF, 2'b11, 2'd3);
    hold = 1'b0;
    wait_idle("s5_done");
    chk("s5_state", 64'(dut.st), 64'(ST_IDLE));
    chk("s5_ovf_sticky", 64'(ovf), 64'd1);

    // reset during an outstanding write
    downloading = 1'b1;
    hold = 1'b1;
    ld_pulse(22'h000005, 16'h5555, 2'b01, 2'd2);
    tick();
    chk("s6_we_pre", 64'(prog_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_we", 64'(prog_we), 64'd0);
    chk("s6_addr", 64'(prog_addr), 64'd0);
    chk("s6_data", 64'(prog_data), 64'd0);
    chk("s6_mask", 64'(prog_mask), 64'd3);
    chk("s6_ba", 64'(prog_ba), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_ovf", 64'(ovf), 64'd0);
    chk("s6_empty", 64'(dut.u_fifo.empty), 64'd1);
    tick();
    rst_n = 1'b1;
    hold = 1'b0;
    downloading = 1'b0;
    clr_en = 1'b0;
    repeat (4) tick();
    chk("s6_post_busy", 64'(busy), 64'd0);
    chk("s6_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
